// File: rtl/vga_text_gen.sv
// rtl/vga_text_gen.sv - VGA text-mode generator: raster timing, char/font fetch, pixel serialiser, blinking cursor
//
// Ports:
//   VGAClk        pixel clock
//   reset         asynchronous active-high reset
//   charAddress   screen-buffer read address (row*COLS+col), combinational from the counters
//   char          screen-buffer data, one cycle after charAddress
//   fontAddress   font ROM address {char, scanline}
//   fontRow       font ROM data, one cycle after fontAddress, bit 7 = leftmost pixel
//   cursorAddress cell index of the cursor
//   cursorEn      cursor enable
//   vga_hsync     horizontal sync (active level HS_POL)
//   vga_vsync     vertical sync (active level VS_POL)
//   vga_sig       monochrome pixel
//   vga_blank     high outside the active area
//   frameStart    one-cycle pulse with the first active pixel of a frame
module vga_text_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int HS_POL     = 0,
    parameter int VS_POL     = 0,
    parameter int CHAR_W     = 8,
    parameter int CHAR_H     = 16,
    parameter int COLS       = 80,
    parameter int ROWS       = 30,
    parameter int BLINK_LOG2 = 5
) (
    input  logic        VGAClk,
    input  logic        reset,
    output logic [11:0] charAddress,
    input  logic [7:0]  char,
    output logic [11:0] fontAddress,
    input  logic [7:0]  fontRow,
    input  logic [11:0] cursorAddress,
    input  logic        cursorEn,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        vga_sig,
    output logic        vga_blank,
    output logic        frameStart
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int XW      = $clog2(H_TOTAL);
    localparam int YW      = $clog2(V_TOTAL);
    localparam int CW_LOG  = $clog2(CHAR_W);
    localparam int FW      = BLINK_LOG2 + 1;

    localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] X_ACT    = XW'(H_ACTIVE);
    localparam logic [XW-1:0] X_TXT    = XW'(COLS * CHAR_W);
    localparam logic [XW-1:0] HS_START = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] Y_ACT    = YW'(V_ACTIVE);
    localparam logic [YW-1:0] Y_TXT    = YW'(ROWS * CHAR_H);
    localparam logic [YW-1:0] Y_TXT_LAST = YW'(ROWS * CHAR_H - 1);
    localparam logic [YW-1:0] VS_START = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [3:0]    SCAN_MASK = 4'(CHAR_H - 1);
    localparam logic [2:0]    PX_MASK   = 3'(CHAR_W - 1);
    localparam logic [11:0]   COLS_W    = 12'(COLS);
    localparam logic          HS_ON     = 1'(HS_POL);
    localparam logic          VS_ON     = 1'(VS_POL);

    // Per-pixel attributes carried alongside the char/font fetch.
    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       blank;
        logic       text;
        logic       cur;
        logic       first;
        logic [2:0] px;
    } pix_t;

    localparam pix_t PIX_IDLE = '{hs: ~HS_ON, vs: ~VS_ON, blank: 1'b1, text: 1'b0,
                                  cur: 1'b0, first: 1'b0, px: 3'd0};

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [11:0]   row_base_q, row_base_d;
    logic [FW-1:0] frame_q, frame_d;
    pix_t          s1_q, s1_d, s2_q, s2_d;
    logic [3:0]    scan1_q, scan1_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          blank_q, blank_d;
    logic          sig_q, sig_d;
    logic          frame_start_q, frame_start_d;

    logic          x_wrap, y_wrap;
    logic [3:0]    scan0;
    logic          text0;

    assign x_wrap      = (x_q == X_LAST);
    assign y_wrap      = (y_q == Y_LAST);
    assign scan0       = 4'(y_q) & SCAN_MASK;
    assign text0       = (x_q < X_TXT) && (y_q < Y_TXT);
    assign charAddress = row_base_q + 12'(x_q >> CW_LOG);
    // Held at zero during reset so the ROM sees a defined address regardless of the RAM output.
    assign fontAddress = reset ? 12'd0 : {char, scan1_q};

    always_comb begin
        x_d           = x_wrap ? '0 : x_q + 1'b1;
        y_d           = y_q;
        row_base_d    = row_base_q;
        frame_d       = frame_q;
        if (x_wrap) begin
            if (y_wrap) begin
                y_d        = '0;
                row_base_d = '0;
                frame_d    = frame_q + FW'(1);
            end else begin
                y_d = y_q + 1'b1;
                // Advance only inside the text rows, so the base parks on the last row.
                if (scan0 == SCAN_MASK && y_q < Y_TXT_LAST)
                    row_base_d = row_base_q + COLS_W;
            end
        end

        s1_d.hs    = (x_q >= HS_START && x_q < HS_END) ? HS_ON : ~HS_ON;
        s1_d.vs    = (y_q >= VS_START && y_q < VS_END) ? VS_ON : ~VS_ON;
        s1_d.blank = !((x_q < X_ACT) && (y_q < Y_ACT));
        s1_d.text  = text0;
        s1_d.cur   = cursorEn && frame_q[BLINK_LOG2] && (charAddress == cursorAddress)
                     && (int'(scan0) >= CHAR_H - 2) && text0;
        s1_d.first = (x_q == '0) && (y_q == '0);
        s1_d.px    = 3'(x_q) & PX_MASK;
        scan1_d    = scan0;
        s2_d       = s1_q;

        hsync_d       = s2_q.hs;
        vsync_d       = s2_q.vs;
        blank_d       = s2_q.blank;
        frame_start_d = s2_q.first;
        sig_d         = s2_q.text && !s2_q.blank && (fontRow[3'd7 - s2_q.px] ^ s2_q.cur);
    end

    always_ff @(posedge VGAClk or posedge reset) begin
        if (reset) begin
            x_q           <= '0;
            y_q           <= '0;
            row_base_q    <= '0;
            frame_q       <= '0;
            s1_q          <= PIX_IDLE;
            s2_q          <= PIX_IDLE;
            scan1_q       <= '0;
            hsync_q       <= ~HS_ON;
            vsync_q       <= ~VS_ON;
            blank_q       <= 1'b1;
            sig_q         <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            row_base_q    <= row_base_d;
            frame_q       <= frame_d;
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            scan1_q       <= scan1_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            blank_q       <= blank_d;
            sig_q         <= sig_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga_hsync  = hsync_q;
    assign vga_vsync  = vsync_q;
    assign vga_blank  = blank_q;
    assign vga_sig    = sig_q;
    assign frameStart = frame_start_q;

endmodule
